// File: rtl/rom_6502_loader.sv
// rom_6502_loader: boot-image writer and verifier for the PIF 6502 program ROM.
// Streams DEPTH bytes into the ROM, reads them back, and releases the CPU on a good checksum.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             1-cycle pulse that begins a load (ignored while busy)
//   expected_sum      host checksum, captured on an accepted start
//   in_data/in_valid  image byte stream; in_ready is high while loading
//   mem_we/mem_wdata  registered ROM write strobe and data
//   mem_oe            registered ROM read request
//   mem_addr          ROM address for either a write or a read; 0 when idle
//   mem_valid/mem_q   ROM read data, one cycle after mem_oe
//   cpu_hold          1 keeps the 6502 in reset
//   busy/done/error   status
module rom_6502_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       expected_sum,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_q,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Counters are one bit wider than the address so they can hold DEPTH itself.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rx_count;
    logic [15:0]       load_sum;
    logic [15:0]       read_sum;
    logic [15:0]       exp_sum;
    logic              beat;
    logic              pass;

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD) || (state == S_VERIFY);
    assign beat     = in_valid && in_ready;

    // Both the readback and the host checksum must agree with what was written.
    assign pass = (read_sum == load_sum) && (load_sum == exp_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_addr   <= '0;
            rd_cnt    <= '0;
            rx_count  <= '0;
            load_sum  <= '0;
            read_sum  <= '0;
            exp_sum   <= '0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // Strobes are single-cycle; the address bus parks at 0 when unused.
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LOAD;
                        wr_addr  <= '0;
                        rd_cnt   <= '0;
                        rx_count <= '0;
                        load_sum <= '0;
                        read_sum <= '0;
                        exp_sum  <= expected_sum;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (beat) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= in_data;
                        load_sum  <= load_sum + 16'(in_data);
                        wr_addr   <= wr_addr + ADR_ONE;
                        if (wr_addr == LAST_A) begin
                            // The last write lands during the first
                            // VERIFY cycle, so reads start one cycle later.
                            state  <= S_VERIFY;
                            rd_cnt <= '0;
                        end
                    end
                end

                S_VERIFY: begin
                    // mem_we was high this cycle only on entry; reads are
                    // issued from the cycle after, one address per cycle.
                    if (!mem_we && rd_cnt != DEPTH_C) begin
                        mem_oe   <= 1'b1;
                        mem_addr <= ADDR_W'(rd_cnt);
                        rd_cnt   <= rd_cnt + CNT_ONE;
                    end
                    if (mem_we && rd_cnt != DEPTH_C) begin
                        mem_oe   <= 1'b0;
                    end
                    if (mem_valid && rx_count != DEPTH_C) begin
                        read_sum <= read_sum + 16'(mem_q);
                        rx_count <= rx_count + CNT_ONE;
                    end
                    // Decision is taken the edge after the last byte arrives.
                    if (rx_count == DEPTH_C) begin
                        if (pass) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_6502_loader.sv
// Testbench for rom_6502_loader: RAM model, scoreboard queues and a monitor.
// Expected writes, reads and outcomes are pushed by the driver and popped by the monitor.
module tb_rom_6502_loader;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       expected_sum;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_oe;
    logic              mem_valid = 1'b0;
    logic [DATA_W-1:0] mem_q = '0;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    rom_6502_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .expected_sum(expected_sum),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_oe      (mem_oe),
        .mem_valid   (mem_valid),
        .mem_q       (mem_q),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: 1-cycle synchronous read, optional stuck-at-0 on bit 0 of addr 5.
    logic [7:0] ram [0:4095];
    bit stuck_en = 1'b0;

    always @(posedge clk) begin
        mem_valid <= mem_oe;
        mem_q     <= mem_oe ? ram[mem_addr] : 8'h00;
        if (mem_we)
            ram[mem_addr] <= (stuck_en && mem_addr == 12'd5)
                           ? (mem_wdata & 8'hFE) : mem_wdata;
    end

    logic [19:0] wq [$];
    logic [11:0] rq [$];
    bit          resq [$];
    logic [7:0]  img [DEPTH];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor
    logic [19:0] w;
    logic [11:0] ra;
    bit          p;
    bit          prev_end = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            check("we_oe_excl", 32'(mem_we & mem_oe), 0);
            if (!mem_we && !mem_oe)
                check("idle_addr", 32'(mem_addr), 0);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h",
                             mem_addr, mem_wdata);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w[19:8]));
                    check("wr_data", 32'(mem_wdata), 32'(w[7:0]));
                end
            end
            if (mem_oe) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read addr=%0h", mem_addr);
                end else begin
                    ra = rq.pop_front();
                    check("rd_addr", 32'(mem_addr), 32'(ra));
                end
            end
            if ((done || error) && !prev_end) begin
                if (resq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end done=%0d error=%0d",
                             done, error);
                end else begin
                    p = resq.pop_front();
                    check("res_done", 32'(done), 32'(p));
                    check("res_error", 32'(error), 32'(!p));
                    check("res_hold", 32'(cpu_hold), 32'(!p));
                end
            end
        end
        prev_end = done || error;
    end

    function automatic logic [15:0] img_sum();
        logic [15:0] s = '0;
        for (int i = 0; i < DEPTH; i++) s += 16'(img[i]);
        return s;
    endfunction

    // Reference outcome: host sum matches the image and readback is faithful.
    function automatic bit model_pass(input logic [15:0] s);
        bit corrupt = stuck_en && img[5][0];
        return (img_sum() == s) && !corrupt;
    endfunction

    task automatic do_start(input logic [15:0] s);
        @(posedge clk);
        #1;
        start = 1'b1;
        expected_sum = s;
        for (int i = 0; i < DEPTH; i++) rq.push_back(12'(i));
        resq.push_back(model_pass(s));
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        expected_sum = $urandom;
        check("start_hold", 32'(cpu_hold), 1);
        check("start_done", 32'(done), 0);
        check("start_err", 32'(error), 0);
        check("start_busy", 32'(busy), 1);
        check("start_ready", 32'(in_ready), 1);
    endtask

    task automatic feed(input int mode, input int count);
        int  n = 0;
        int  g = 0;
        bit  acc;
        bit  tog = 1'b1;
        while (n < count && g < 2000) begin
            case (mode)
                0: in_valid = 1'b1;
                1: begin
                    in_valid = tog;
                    tog = !tog;
                end
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = img[n];
            acc = in_valid && in_ready;
            if (acc) wq.push_back({12'(n), img[n]});
            @(posedge clk);
            #1;
            if (acc) n++;
            g++;
        end
        in_valid = 1'b0;
        in_data = '0;
        check("feed_beats", 32'(n), 32'(count));
        if (n == DEPTH) check("ready_after", 32'(in_ready), 0);
    endtask

    task automatic wait_end(output int lat);
        int g = 0;
        while (!(done || error) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        lat = cyc - t0;
        check("end_reached", 32'(done || error), 1);
    endtask

    task automatic run(input logic [15:0] s, input int mode);
        int lat;
        do_start(s);
        feed(mode, DEPTH);
        wait_end(lat);
        if (mode == 0) check("latency", 32'(lat), 36);
    endtask

    initial begin
        int bad;
        int mode;
        logic [15:0] s;

        reset = 1'b1;
        start = 1'b0;
        expected_sum = '0;
        in_data = '0;
        in_valid = 1'b0;
        #1;
        check("rst_hold", 32'(cpu_hold), 1);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_oe", 32'(mem_oe), 0);
        check("rst_addr", 32'(mem_addr), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Ramp image, correct sum, in_valid held high.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        run(16'h0078, 0);

        // Same image, wrong host sum; also starts from DONE.
        run(16'h0079, 0);

        // in_valid toggled every cycle.
        run(16'h0078, 1);

        // Stuck bit in the ROM corrupts the readback.
        stuck_en = 1'b1;
        run(16'h0078, 0);
        stuck_en = 1'b0;

        // Reset after the 8th beat.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        do_start(img_sum());
        feed(0, 8);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_ready", 32'(in_ready), 0);
        check("mid_hold", 32'(cpu_hold), 1);
        check("mid_busy", 32'(busy), 0);
        check("mid_we", 32'(mem_we), 0);
        check("mid_oe", 32'(mem_oe), 0);
        wq.delete();
        rq.delete();
        resq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(img_sum(), 0);

        // From DONE: all-0xFF image.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
        run(16'h0FF0, 0);

        // Random images, gaps and sums.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            bad = $urandom_range(0, 1);
            mode = $urandom_range(0, 2);
            s = img_sum();
            if (bad != 0) s = s + 16'($urandom_range(1, 16'hFFFF));
            run(s, mode);
        end

        repeat (3) @(posedge clk);
        #1;
        check("wq_empty", 32'(wq.size()), 0);
        check("rq_empty", 32'(rq.size()), 0);
        check("resq_empty", 32'(resq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
